// File: rtl/abacus_snapshot_master.sv
// abacus_snapshot_master: reads NUM_WORDS counter words over Wishbone
// and streams each one out on a valid/ready handshake.
module abacus_snapshot_master #(
  parameter logic [31:0] BASE_ADDR      = 32'hF003_0100,
  parameter int          NUM_WORDS      = 10,
  parameter int          TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  output logic        wb_cyc,
  output logic        wb_stb,
  output logic        wb_we,
  output logic [31:0] wb_adr,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [5:0]  out_index,
  output logic        out_last,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam logic [5:0] LAST_IDX = 6'(NUM_WORDS - 1);
  localparam logic [7:0] TMO_MAX  = 8'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    OUT
  } state_t;

  state_t      state, state_n;
  logic [5:0]  idx, idx_n;
  logic [7:0]  tmo, tmo_n;
  logic [31:0] adr, adr_n;
  logic [31:0] data, data_n;
  logic        err, err_n;
  logic        cyc_q, vld_q, last_q;
  logic        fin;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= IDLE;
      idx    <= '0;
      tmo    <= '0;
      adr    <= BASE_ADDR;
      data   <= '0;
      err    <= 1'b0;
      cyc_q  <= 1'b0;
      vld_q  <= 1'b0;
      last_q <= 1'b0;
    end else begin
      state  <= state_n;
      idx    <= idx_n;
      tmo    <= tmo_n;
      adr    <= adr_n;
      data   <= data_n;
      err    <= err_n;
      cyc_q  <= (state_n == REQ);
      vld_q  <= (state_n == OUT);
      last_q <= (state_n == OUT) && (idx_n == LAST_IDX);
    end
  end

  // abort outranks both ack capture and the output transfer
  always_comb begin
    state_n = state;
    idx_n   = idx;
    tmo_n   = tmo;
    adr_n   = adr;
    data_n  = data;
    err_n   = err;
    fin     = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_n = REQ;
          idx_n   = '0;
          tmo_n   = '0;
          adr_n   = BASE_ADDR;
          err_n   = 1'b0;
        end
      end
      REQ: begin
        if (abort) begin
          state_n = IDLE;
        end else if (wb_ack) begin
          data_n  = wb_dat_i;
          state_n = OUT;
        end else begin
          tmo_n = tmo + 8'd1;
          if (tmo_n == TMO_MAX) begin
            state_n = IDLE;
            err_n   = 1'b1;
          end
        end
      end
      OUT: begin
        if (abort) begin
          state_n = IDLE;
        end else if (out_ready) begin
          if (last_q) begin
            fin     = 1'b1;
            state_n = IDLE;
          end else begin
            idx_n   = idx + 6'd1;
            adr_n   = adr + 32'd4;
            tmo_n   = '0;
            state_n = REQ;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign wb_cyc    = cyc_q;
  assign wb_stb    = cyc_q;
  assign wb_we     = 1'b0;
  assign wb_adr    = adr;
  assign wb_dat_o  = '0;
  assign out_valid = vld_q;
  assign out_data  = data;
  assign out_index = idx;
  assign out_last  = last_q;
  assign busy      = (state != IDLE);
  assign done      = fin;
  assign error     = err;

endmodule

// File: tb/tb_abacus_snapshot_master.sv
// Bench for abacus_snapshot_master: directed scenarios scored against
// a transfer-level reference model plus literal cycle expectations.
module tb_abacus_snapshot_master;

  localparam logic [31:0] BASE = 32'hF003_0100;
  localparam int NW  = 10;
  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst, start, abort;
  logic        wb_cyc, wb_stb, wb_we;
  logic [31:0] wb_adr, wb_dat_o, wb_dat_i;
  logic        wb_ack;
  logic        out_valid, out_ready, out_last;
  logic [31:0] out_data;
  logic [5:0]  out_index;
  logic        busy, done, error;

  logic        ack_r, force_ack, slave_en;
  logic        s_ack;
  logic [31:0] s_idx;

  int n_chk  = 0;
  int n_fail = 0;
  int cycle  = 0;
  int xfers  = 0;
  int dones  = 0;
  int acks   = 0;
  int m_word = 0;
  int t0, dc, x0, a0, d0, v;

  assign wb_ack = ack_r | force_ack;

  abacus_snapshot_master #(
    .BASE_ADDR     (BASE),
    .NUM_WORDS     (NW),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .abort    (abort),
    .wb_cyc   (wb_cyc),
    .wb_stb   (wb_stb),
    .wb_we    (wb_we),
    .wb_adr   (wb_adr),
    .wb_dat_o (wb_dat_o),
    .wb_dat_i (wb_dat_i),
    .wb_ack   (wb_ack),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_index(out_index),
    .out_last (out_last),
    .busy     (busy),
    .done     (done),
    .error    (error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic wait_done(input int lim, output int at);
    at = -1;
    for (int i = 0; i < lim; i++) begin
      tick();
      at_neg();
      if (done) begin
        at = cycle;
        break;
      end
    end
    if (at < 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL wait_done: no done in %0d cycles, expected one", lim);
    end
  endtask

  task automatic wait_req(input logic [31:0] a, input int lim);
    int hit;
    hit = 0;
    for (int i = 0; i < lim; i++) begin
      tick();
      at_neg();
      if (wb_stb && wb_adr == a) begin
        hit = 1;
        break;
      end
    end
    if (hit == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL wait_req: no read of %0h in %0d cycles", a, lim);
    end
  endtask

  // slave acks one cycle after seeing cyc&stb&~ack, data = 0x100 + word
  initial begin
    ack_r    = 1'b0;
    wb_dat_i = '0;
    forever begin
      @(negedge clk);
      s_ack = slave_en && wb_cyc && wb_stb && !wb_ack;
      s_idx = (wb_adr - BASE) >> 2;
      @(posedge clk);
      #1;
      ack_r    = s_ack;
      wb_dat_i = s_ack ? 32'h100 + s_idx : 32'h0;
    end
  end

  // reference model: word counter advanced by accepted output transfers
  always @(negedge clk) begin
    if (!rst) begin
      m_word = 0;
    end else begin
      chk("wb_we", wb_we, 0);
      chk("wb_dat_o", wb_dat_o, 0);
      chk("cyc_vs_stb", wb_cyc, wb_stb);
      chk("busy", busy, wb_cyc | out_valid);
      if (wb_stb)
        chk("wb_adr", wb_adr, BASE + 32'(4 * m_word));
      if (out_valid) begin
        chk("out_index", out_index, m_word);
        chk("out_data", out_data, 32'h100 + m_word);
        chk("out_last", out_last, m_word == NW - 1);
      end else begin
        chk("out_last_idle", out_last, 0);
      end
      chk("done", done,
          out_valid && out_ready && (m_word == NW - 1) && !abort);
      if (wb_ack && wb_stb) acks++;
      if (done) dones++;
      if (!busy && start) begin
        m_word = 0;
      end else if (out_valid && out_ready && !abort) begin
        xfers++;
        m_word = (m_word == NW - 1) ? 0 : m_word + 1;
      end
    end
  end

  initial begin
    rst       = 1'b0;
    start     = 1'b0;
    abort     = 1'b0;
    out_ready = 1'b1;
    slave_en  = 1'b1;
    force_ack = 1'b0;
    repeat (3) tick();
    at_neg();
    chk("rst_busy", busy, 0);
    chk("rst_cyc", wb_cyc, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_data", out_data, 0);
    chk("rst_index", out_index, 0);
    chk("rst_adr", wb_adr, BASE);
    tick();
    rst = 1'b1;

    // nominal snapshot
    tick();
    start = 1'b1;
    t0 = cycle;
    x0 = xfers;
    a0 = acks;
    d0 = dones;
    at_neg();
    chk("nom_busy0", busy, 0);
    tick();
    start = 1'b0;
    at_neg();
    chk("nom_stb1", wb_stb, 1);
    chk("nom_adr1", wb_adr, BASE);
    tick();
    at_neg();
    chk("nom_ack2", wb_ack, 1);
    chk("nom_valid2", out_valid, 0);
    tick();
    at_neg();
    chk("nom_valid3", out_valid, 1);
    chk("nom_data3", out_data, 32'h100);
    wait_done(60, dc);
    chk("nom_done_cycle", dc - t0, 30);
    chk("nom_last_data", out_data, 32'h109);
    chk("nom_last_index", out_index, 9);
    chk("nom_last_flag", out_last, 1);
    tick();
    at_neg();
    chk("nom_busy31", busy, 0);
    chk("nom_done31", done, 0);
    chk("nom_xfers", xfers - x0, 10);
    chk("nom_acks", acks - a0, 10);
    chk("nom_dones", dones - d0, 1);

    // backpressure at word 3, with a stray start during the stall
    tick();
    start = 1'b1;
    at_neg();
    tick();
    start = 1'b0;
    wait_req(BASE + 32'd12, 40);
    tick();
    out_ready = 1'b0;
    a0 = acks;
    at_neg();
    for (int i = 0; i < 5; i++) begin
      tick();
      start = (i == 2);
      at_neg();
      chk("bp_valid", out_valid, 1);
      chk("bp_index", out_index, 3);
      chk("bp_data", out_data, 32'h103);
      chk("bp_stb", wb_stb, 0);
    end
    tick();
    start = 1'b0;
    out_ready = 1'b1;
    at_neg();
    chk("bp_xfer_valid", out_valid, 1);
    chk("bp_xfer_stb", wb_stb, 0);
    tick();
    at_neg();
    chk("bp_stb4", wb_stb, 1);
    chk("bp_adr4", wb_adr, BASE + 32'd16);
    wait_done(60, dc);
    chk("bp_acks", acks - a0, 7);

    // timeout with a silent slave
    tick();
    slave_en = 1'b0;
    start = 1'b1;
    d0 = dones;
    at_neg();
    tick();
    start = 1'b0;
    for (int i = 0; i < TMO; i++) begin
      at_neg();
      chk("to_stb", wb_stb, 1);
      tick();
    end
    at_neg();
    chk("to_stb_off", wb_stb, 0);
    chk("to_error", error, 1);
    chk("to_busy", busy, 0);
    chk("to_no_done", dones - d0, 0);
    tick();
    slave_en = 1'b1;
    start = 1'b1;
    at_neg();
    chk("to_err_held", error, 1);
    tick();
    start = 1'b0;
    at_neg();
    chk("to_err_clr", error, 0);
    wait_done(60, dc);
    chk("to_err_end", error, 0);

    // abort coinciding with ack on word 2
    tick();
    start = 1'b1;
    d0 = dones;
    at_neg();
    tick();
    start = 1'b0;
    wait_req(BASE + 32'd8, 40);
    tick();
    abort = 1'b1;
    at_neg();
    chk("ab_ack", wb_ack, 1);
    tick();
    abort = 1'b0;
    at_neg();
    chk("ab_busy", busy, 0);
    chk("ab_valid", out_valid, 0);
    chk("ab_stb", wb_stb, 0);
    chk("ab_error", error, 0);
    v = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      at_neg();
      if (out_valid) v++;
    end
    chk("ab_no_valid", v, 0);
    chk("ab_no_done", dones - d0, 0);
    chk("ab_data_kept", out_data, 32'h101);

    // stray ack while idle
    tick();
    force_ack = 1'b1;
    at_neg();
    tick();
    force_ack = 1'b0;
    at_neg();
    chk("late_busy", busy, 0);
    chk("late_valid", out_valid, 0);
    chk("late_data", out_data, 32'h101);

    // reset during REQ with ack and start both high
    tick();
    start = 1'b1;
    at_neg();
    tick();
    start = 1'b0;
    at_neg();
    tick();
    rst = 1'b0;
    start = 1'b1;
    at_neg();
    chk("rs_ack", wb_ack, 1);
    chk("rs_stb", wb_stb, 1);
    tick();
    rst = 1'b1;
    start = 1'b0;
    at_neg();
    chk("rs_busy", busy, 0);
    chk("rs_cyc", wb_cyc, 0);
    chk("rs_stb_off", wb_stb, 0);
    chk("rs_valid", out_valid, 0);
    chk("rs_last", out_last, 0);
    chk("rs_done", done, 0);
    chk("rs_error", error, 0);
    chk("rs_data", out_data, 0);
    chk("rs_index", out_index, 0);
    chk("rs_adr", wb_adr, BASE);
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/abacus_snapshot_master.md
ABACUS_SNAPSHOT_MASTER -- requirements
Module: abacus_snapshot_master

Interface
REQ-001 Parameter BASE_ADDR, default 32'hF003_0100, SHALL be the byte address of the first counter word read.
REQ-002 Parameter NUM_WORDS, default 10, range 1..64, SHALL be the number of consecutive 32-bit words read per snapshot.
REQ-003 Parameter TIMEOUT_CYCLES, default 255, range 1..255, SHALL be the maximum number of REQ cycles without wb_ack before the transfer aborts.
REQ-004 clk  in  1  sole clock; all logic on its rising edge.
REQ-005 rst  in  1  reset, synchronous and active-low (asserted when 0).
REQ-006 start  in  1  single-cycle request to begin a snapshot.
REQ-007 abort  in  1  single-cycle request to cancel a snapshot in progress.
REQ-008 wb_cyc, wb_stb  out  1 each  Wishbone master cycle and strobe.
REQ-009 wb_we  out  1  write enable; always 0.
REQ-010 wb_adr  out  32  byte address of the current read.
REQ-011 wb_dat_o  out  32  write data; always 0.
REQ-012 wb_dat_i  in  32  read data from the slave; valid in the cycle wb_ack is 1.
REQ-013 wb_ack  in  1  slave acknowledge.
REQ-014 out_valid / out_ready  out / in  1 each  output stream handshake.
REQ-015 out_data  out  32  captured counter word.
REQ-016 out_index  out  6  word index of out_data (0..NUM_WORDS-1).
REQ-017 out_last  out  1  marks the final word of a snapshot.
REQ-018 busy  out  1  high in every state except IDLE.
REQ-019 done  out  1  single-cycle pulse on successful completion.
REQ-020 error  out  1  sticky timeout flag.

Function
REQ-021 The FSM SHALL have exactly three states: IDLE, REQ and OUT.
REQ-022 IDLE->REQ SHALL occur when start=1, with word index cleared to 0, the timeout counter cleared and error cleared; start SHALL be ignored in REQ and OUT.
REQ-023 In REQ: wb_cyc=wb_stb=1 and wb_adr=BASE_ADDR+4*index, all driven from registers.
REQ-024 In REQ with wb_ack=1: wb_dat_i SHALL be captured into out_data, wb_cyc/wb_stb SHALL be 0 from the next cycle and the FSM SHALL go to OUT.
REQ-025 Bus signals SHALL deassert in the cycle after ack, so a slave that registers ack as cyc&stb&~ack produces exactly one ack per word.
REQ-026 In REQ each cycle with wb_ack=0 SHALL increment an 8-bit timeout counter; on reaching TIMEOUT_CYCLES the block SHALL drop wb_cyc/wb_stb, set error=1, pulse done=0 and return to IDLE.
REQ-027 In OUT: out_valid=1, with out_data/out_index held stable until out_valid&out_ready, and out_last=(index==NUM_WORDS-1).
REQ-028 On a transfer in OUT with out_last=0: index SHALL increment, the timeout counter SHALL clear and the FSM SHALL go to REQ.
REQ-029 On a transfer in OUT with out_last=1: done SHALL pulse for one cycle and the FSM SHALL go to IDLE.
REQ-030 abort=1 in REQ or OUT SHALL return the FSM to IDLE next cycle with wb_cyc/wb_stb/out_valid=0, no done pulse, and error unchanged; abort SHALL take priority over wb_ack and over the output transfer in the same cycle.
REQ-031 A late wb_ack arriving in IDLE SHALL be ignored.
REQ-032 Minimum latency with a single-cycle-ack slave: start at cycle 0 -> stb at 1 -> ack at 2 -> out_valid at 3; 3 cycles per word with out_ready held at 1.
REQ-033 The address SHALL be computed as a 32-bit sum with wrap-around modulo 2^32.

Reset
REQ-034 When rst=0 at a clock edge: FSM=IDLE and wb_cyc, wb_stb, out_valid, out_last, busy, done, error=0; out_data=0; out_index=0; wb_adr=BASE_ADDR; timeout counter=0.
REQ-035 Reset asserted mid-snapshot SHALL take effect at the next edge regardless of wb_ack, start or abort.

Verification
REQ-036 Nominal: NUM_WORDS=10, the slave returns 0x100+i, out_ready=1, start pulsed -> 10 words with out_index 0..9 and data 0x100..0x109, out_last only on index 9, done at cycle 30, busy 1..30.
REQ-037 Backpressure: out_ready low for 5 cycles at index 3 -> out_data/out_index stable, wb_stb=0 throughout, no extra bus read, and word 4 requested the cycle after the transfer.
REQ-038 Timeout: TIMEOUT_CYCLES=4, slave never acks -> stb high for exactly 4 cycles, then error=1, no done, IDLE; a new start clears error.
REQ-039 Abort with ack in the same cycle at index 2 -> IDLE next cycle, no out_valid for word 2, no done.
REQ-040 Reset: rst=0 while in REQ with wb_ack=1 -> all outputs at REQ-034 values next cycle; start issued during busy -> no effect.
